// File: rtl/exc_pkg.sv
// Shared constants for the exception commit unit: ExcCodes, default source
// ordering, the exception vector and CP0 Status/Cause bit positions.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam int DEF_NUM_SRC = 8;

    // Source i occupies bits [i*5 +: 5]; index 0 (fetch AdEL) is listed last here.
    localparam logic [DEF_NUM_SRC*5-1:0] EXC_CODES_DEF = {
        EXC_ADES, EXC_ADEL, EXC_TR, EXC_BP, EXC_SYS, EXC_OV, EXC_RI, EXC_ADEL
    };

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    localparam int ST_IE       = 0;
    localparam int ST_EXL      = 1;
    localparam int ST_IM_LO    = 8;
    localparam int ST_IM_HI    = 15;
    localparam int CA_IP_SW_LO = 8;
    localparam int CA_IP_SW_HI = 9;

endpackage

// File: rtl/exc_commit_unit_int_sync.sv
// Multi-stage synchroniser for the external interrupt lines, cleared
// asynchronously so no stale request survives reset.
module int_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        sync_d[0] = async_i;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_commit_unit.sv
// MEM/WB exception arbiter: picks interrupt / synchronous exception / ERET
// and emits registered one-cycle flush, redirect and CP0 write pulses.
module exc_commit_unit
    import exc_pkg::*;
#(
    parameter int                    NUM_SRC        = 8,
    parameter int                    HW_INT         = 6,
    parameter int                    SYNC_STAGES    = 2,
    parameter logic [NUM_SRC*5-1:0]  EXC_CODES      = EXC_CODES_DEF,
    parameter logic [NUM_SRC-1:0]    PC_BADV_MASK   = 8'b0000_0001,
    parameter logic [NUM_SRC-1:0]    DATA_BADV_MASK = 8'b1100_0000,
    parameter logic [31:0]           EXC_VECTOR     = EXC_VECTOR_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stall_i,
    input  logic               inst_valid_i,
    input  logic [31:0]        pc_i,
    input  logic               in_delay_slot_i,
    input  logic [NUM_SRC-1:0] exc_src_i,
    input  logic               eret_i,
    input  logic [31:0]        bad_addr_i,
    input  logic [HW_INT-1:0]  hw_int_i,
    input  logic [31:0]        status_i,
    input  logic [31:0]        cause_i,
    input  logic [31:0]        epc_i,
    output logic               flush_o,
    output logic [31:0]        new_pc_o,
    output logic               exc_we_o,
    output logic [4:0]         exccode_o,
    output logic [31:0]        epc_o,
    output logic               bd_o,
    output logic               badv_we_o,
    output logic [31:0]        badvaddr_o,
    output logic               eret_o,
    output logic [HW_INT-1:0]  hw_ip_o
);

    logic [HW_INT-1:0] hw_ip;

    int_sync #(.STAGES(SYNC_STAGES), .WIDTH(HW_INT)) u_int_sync (
        .clk    (clk),
        .rst_n  (resetn),
        .async_i(hw_int_i),
        .sync_o (hw_ip)
    );

    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        exc_we_q, exc_we_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic        badv_we_q, badv_we_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        eret_q, eret_d;
    logic        block_q, block_d;

    logic [7:0]  ip_vec;
    logic        int_pend, accept, take_exc, take_eret;
    logic        src_hit, src_badv_pc, src_badv_data;
    logic [4:0]  src_code;

    always_comb begin
        ip_vec   = 8'({hw_ip, cause_i[CA_IP_SW_HI:CA_IP_SW_LO]});
        int_pend = (|(ip_vec & status_i[ST_IM_HI:ST_IM_LO])) && status_i[ST_IE]
                   && !status_i[ST_EXL] && !block_q;

        // Descending scan so the lowest-index request is the one left standing.
        src_hit       = 1'b0;
        src_code      = '0;
        src_badv_pc   = 1'b0;
        src_badv_data = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (exc_src_i[i]) begin
                src_hit       = 1'b1;
                src_code      = EXC_CODES[i*5 +: 5];
                src_badv_pc   = PC_BADV_MASK[i];
                src_badv_data = DATA_BADV_MASK[i];
            end
        end

        // The cycle after a flush carries a squashed instruction; never commit it.
        accept    = inst_valid_i && !stall_i && !flush_q;
        take_exc  = accept && (int_pend || src_hit);
        take_eret = accept && !int_pend && !src_hit && eret_i;

        flush_d    = 1'b0;
        exc_we_d   = 1'b0;
        badv_we_d  = 1'b0;
        eret_d     = 1'b0;
        new_pc_d   = new_pc_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        badvaddr_d = badvaddr_q;
        block_d    = status_i[ST_EXL] ? 1'b0 : block_q;

        if (take_exc) begin
            flush_d   = 1'b1;
            exc_we_d  = 1'b1;
            new_pc_d  = EXC_VECTOR;
            exccode_d = int_pend ? EXC_INT : src_code;
            bd_d      = in_delay_slot_i;
            epc_d     = in_delay_slot_i ? pc_i - 32'd4 : pc_i;
            if (!int_pend && (src_badv_pc || src_badv_data)) begin
                badv_we_d  = 1'b1;
                badvaddr_d = src_badv_pc ? pc_i : bad_addr_i;
            end
            block_d   = 1'b1;
        end else if (take_eret) begin
            flush_d  = 1'b1;
            eret_d   = 1'b1;
            new_pc_d = epc_i;
            block_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
            exc_we_q   <= 1'b0;
            exccode_q  <= '0;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            badv_we_q  <= 1'b0;
            badvaddr_q <= '0;
            eret_q     <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
            exc_we_q   <= exc_we_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            badv_we_q  <= badv_we_d;
            badvaddr_q <= badvaddr_d;
            eret_q     <= eret_d;
            block_q    <= block_d;
        end
    end

    assign flush_o    = flush_q;
    assign new_pc_o   = new_pc_q;
    assign exc_we_o   = exc_we_q;
    assign exccode_o  = exccode_q;
    assign epc_o      = epc_q;
    assign bd_o       = bd_q;
    assign badv_we_o  = badv_we_q;
    assign badvaddr_o = badvaddr_q;
    assign eret_o     = eret_q;
    assign hw_ip_o    = hw_ip;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed bench for exc_commit_unit: hand-computed expectations checked
// with immediate assertions one cycle after each accept edge.
module tb_exc_commit_unit;

    logic        clk, resetn, stall_i, inst_valid_i, in_delay_slot_i, eret_i;
    logic [31:0] pc_i, bad_addr_i, status_i, cause_i, epc_i;
    logic [7:0]  exc_src_i;
    logic [5:0]  hw_int_i;
    logic        flush_o, exc_we_o, bd_o, badv_we_o, eret_o;
    logic [31:0] new_pc_o, epc_o, badvaddr_o;
    logic [4:0]  exccode_o;
    logic [5:0]  hw_ip_o;

    int tests = 0;
    int fails = 0;

    exc_commit_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .stall_i        (stall_i),
        .inst_valid_i   (inst_valid_i),
        .pc_i           (pc_i),
        .in_delay_slot_i(in_delay_slot_i),
        .exc_src_i      (exc_src_i),
        .eret_i         (eret_i),
        .bad_addr_i     (bad_addr_i),
        .hw_int_i       (hw_int_i),
        .status_i       (status_i),
        .cause_i        (cause_i),
        .epc_i          (epc_i),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .exc_we_o       (exc_we_o),
        .exccode_o      (exccode_o),
        .epc_o          (epc_o),
        .bd_o           (bd_o),
        .badv_we_o      (badv_we_o),
        .badvaddr_o     (badvaddr_o),
        .eret_o         (eret_o),
        .hw_ip_o        (hw_ip_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; stall_i = 1'b0; inst_valid_i = 1'b0; in_delay_slot_i = 1'b0;
        eret_i = 1'b0; pc_i = '0; bad_addr_i = '0; status_i = '0; cause_i = '0;
        epc_i = '0; exc_src_i = '0; hw_int_i = '0;
        step(2);
        chk("rst_flush",   32'(flush_o), 32'd0);
        chk("rst_exc_we",  32'(exc_we_o), 32'd0);
        chk("rst_eret",    32'(eret_o), 32'd0);
        chk("rst_badv_we", 32'(badv_we_o), 32'd0);
        chk("rst_new_pc",  new_pc_o, 32'd0);
        chk("rst_exccode", 32'(exccode_o), 32'd0);
        chk("rst_epc",     epc_o, 32'd0);
        chk("rst_bd",      32'(bd_o), 32'd0);
        chk("rst_badv",    badvaddr_o, 32'd0);
        chk("rst_hw_ip",   32'(hw_ip_o), 32'd0);
        resetn = 1'b1;

        // Overflow in a delay slot
        inst_valid_i = 1'b1; exc_src_i = 8'h04; pc_i = 32'h8000_0010; in_delay_slot_i = 1'b1;
        step(1);
        chk("ov_flush",   32'(flush_o), 32'd1);
        chk("ov_exc_we",  32'(exc_we_o), 32'd1);
        chk("ov_code",    32'(exccode_o), 32'd12);
        chk("ov_epc",     epc_o, 32'h8000_000C);
        chk("ov_bd",      32'(bd_o), 32'd1);
        chk("ov_new_pc",  new_pc_o, 32'hBFC0_0380);
        chk("ov_badv_we", 32'(badv_we_o), 32'd0);
        chk("ov_eret",    32'(eret_o), 32'd0);
        step(1);
        chk("post_flush_flush",  32'(flush_o), 32'd0);
        chk("post_flush_exc_we", 32'(exc_we_o), 32'd0);
        exc_src_i = '0; in_delay_slot_i = 1'b0;
        step(1);
        chk("ov_epc_hold", epc_o, 32'h8000_000C);

        // Priority: fetch AdEL beats ADES, BadVAddr from PC
        exc_src_i = 8'h81; pc_i = 32'hBFC0_0003; bad_addr_i = 32'h1234_5678;
        step(1);
        chk("pri_code",    32'(exccode_o), 32'd4);
        chk("pri_badv_we", 32'(badv_we_o), 32'd1);
        chk("pri_badv",    badvaddr_o, 32'hBFC0_0003);
        chk("pri_epc",     epc_o, 32'hBFC0_0003);
        chk("pri_bd",      32'(bd_o), 32'd0);
        exc_src_i = '0;
        step(1);
        chk("pri_badv_we_pulse", 32'(badv_we_o), 32'd0);
        chk("pri_badv_hold",     badvaddr_o, 32'hBFC0_0003);

        exc_src_i = 8'h80;
        step(1);
        chk("ades_code", 32'(exccode_o), 32'd5);
        chk("ades_badv", badvaddr_o, 32'h1234_5678);
        exc_src_i = '0;
        step(1);

        exc_src_i = 8'h02;
        step(1);
        chk("ri_code",      32'(exccode_o), 32'd10);
        chk("ri_badv_we",   32'(badv_we_o), 32'd0);
        chk("ri_badv_hold", badvaddr_o, 32'h1234_5678);
        exc_src_i = '0; status_i = 32'h2;
        step(1);

        // Interrupt (software IP0) beats the exception
        status_i = 32'h0000_0101; cause_i = 32'h0000_0100; exc_src_i = 8'h81;
        step(1);
        chk("int_pri_flush",   32'(flush_o), 32'd1);
        chk("int_pri_code",    32'(exccode_o), 32'd0);
        chk("int_pri_badv_we", 32'(badv_we_o), 32'd0);
        exc_src_i = '0;
        step(1);
        chk("int_after_flush", 32'(flush_o), 32'd0);
        step(1);
        chk("int_blocked", 32'(flush_o), 32'd0);
        status_i = 32'h0000_0103;
        step(1);
        chk("int_exl_masked", 32'(flush_o), 32'd0);
        status_i = 32'h0000_0101;
        step(1);
        chk("int_unblocked_flush", 32'(flush_o), 32'd1);
        chk("int_unblocked_code",  32'(exccode_o), 32'd0);
        cause_i = '0; status_i = '0;
        step(1);

        // ERET
        eret_i = 1'b1; epc_i = 32'h8000_1234;
        step(1);
        chk("eret_flush",  32'(flush_o), 32'd1);
        chk("eret_eret",   32'(eret_o), 32'd1);
        chk("eret_new_pc", new_pc_o, 32'h8000_1234);
        chk("eret_exc_we", 32'(exc_we_o), 32'd0);
        eret_i = 1'b0;
        step(1);
        chk("eret_pulse", 32'(eret_o), 32'd0);

        // Hardware interrupt through the synchroniser (block cleared by ERET)
        pc_i = 32'h8000_0100; status_i = 32'h0000_0401; hw_int_i = 6'b000001;
        step(1);
        chk("hw_s1_ip",    32'(hw_ip_o), 32'd0);
        chk("hw_s1_flush", 32'(flush_o), 32'd0);
        step(1);
        chk("hw_s2_ip",    32'(hw_ip_o), 32'd1);
        chk("hw_s2_flush", 32'(flush_o), 32'd0);
        step(1);
        chk("hw_flush",  32'(flush_o), 32'd1);
        chk("hw_code",   32'(exccode_o), 32'd0);
        chk("hw_epc",    epc_o, 32'h8000_0100);
        chk("hw_new_pc", new_pc_o, 32'hBFC0_0380);
        step(1);
        chk("hw_post_flush", 32'(flush_o), 32'd0);
        step(1);
        chk("hw_blocked", 32'(flush_o), 32'd0);
        hw_int_i = '0; status_i = 32'h2;
        step(1);

        // Stall holds off a SYS request
        status_i = '0; exc_src_i = 8'h08; stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("stall_flush",  32'(flush_o), 32'd0);
            chk("stall_exc_we", 32'(exc_we_o), 32'd0);
        end
        stall_i = 1'b0;
        step(1);
        chk("stall_rel_flush", 32'(flush_o), 32'd1);
        chk("stall_rel_code",  32'(exccode_o), 32'd8);
        step(1);
        chk("stall_pulse", 32'(flush_o), 32'd0);
        exc_src_i = '0; status_i = 32'h2;
        step(1);

        // No valid instruction: pending interrupt waits
        inst_valid_i = 1'b0; status_i = 32'h0000_0101; cause_i = 32'h0000_0100;
        step(1);
        chk("noval_flush0", 32'(flush_o), 32'd0);
        step(1);
        chk("noval_flush1", 32'(flush_o), 32'd0);
        inst_valid_i = 1'b1;
        step(1);
        chk("val_flush", 32'(flush_o), 32'd1);
        chk("val_code",  32'(exccode_o), 32'd0);

        // Reset in the middle of the commit pulse
        resetn = 1'b0;
        #1;
        chk("midrst_flush",   32'(flush_o), 32'd0);
        chk("midrst_exc_we",  32'(exc_we_o), 32'd0);
        chk("midrst_new_pc",  new_pc_o, 32'd0);
        chk("midrst_epc",     epc_o, 32'd0);
        cause_i = '0; status_i = '0;
        step(1);
        resetn = 1'b1;
        step(1);
        chk("after_rst_flush", 32'(flush_o), 32'd0);
        exc_src_i = 8'h04;
        step(1);
        chk("fresh_flush", 32'(flush_o), 32'd1);
        chk("fresh_code",  32'(exccode_o), 32'd12);
        exc_src_i = '0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exc_commit_unit.md
Name: exc_commit_unit

Overview:
- Parametrised successor to the combinational exception-type encoder.
- Sits at the MEM/WB boundary. Synchronises hardware interrupts and arbitrates N synchronous exception sources plus interrupt and ERET.
- Produces registered, single-cycle commit pulses: pipeline flush, redirect PC, and CP0 write data (ExcCode, EPC, BD, BadVAddr).
- Holds off commit while the pipeline is stalled, and blocks re-entry until CP0 reflects EXL.

Parameters:
- NUM_SRC, 8, number of synchronous exception request lines; index 0 has the highest priority.
- HW_INT, 6, number of external hardware interrupt lines.
- SYNC_STAGES, 2, flop stages on hw_int_i (minimum 2).
- EXC_CODES, package default table, NUM_SRC*5-bit packed ExcCode per source.
- PC_BADV_MASK, 8'b0000_0001, sources whose BadVAddr is pc_i (fetch address errors).
- DATA_BADV_MASK, 8'b1100_0000, sources whose BadVAddr is bad_addr_i.
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- stall_i  in  1  MEM stage stalled; no commit this cycle
- inst_valid_i  in  1  MEM stage holds a real instruction
- pc_i  in  32  MEM stage PC
- in_delay_slot_i  in  1  MEM instruction is in a branch delay slot
- exc_src_i  in  NUM_SRC  exception requests for the MEM instruction
- eret_i  in  1  MEM instruction is ERET
- bad_addr_i  in  32  faulting data address
- hw_int_i  in  HW_INT  asynchronous external interrupts
- status_i  in  32  CP0 Status (IE bit 0, EXL bit 1, IM bits 15:8)
- cause_i  in  32  CP0 Cause (IP1..0 bits 9:8 software)
- epc_i  in  32  CP0 EPC, the ERET target
- flush_o  out  1  one-cycle flush of IF..MEM
- new_pc_o  out  32  redirect target, valid with flush_o
- exc_we_o  out  1  one-cycle CP0 exception write strobe
- exccode_o  out  5  ExcCode to write into Cause[6:2]
- epc_o  out  32  EPC value
- bd_o  out  1  Cause.BD value
- badv_we_o  out  1  BadVAddr write strobe
- badvaddr_o  out  32  BadVAddr value
- eret_o  out  1  one-cycle strobe that clears Status.EXL
- hw_ip_o  out  HW_INT  synchronised interrupt lines, for Cause.IP[7:2]

Behaviour:
- Reset (asynchronous, resetn=0): every output 0; synchroniser flops 0; block flag 0. This applies mid-commit too: a pulse in flight is dropped.
- Synchroniser: hw_ip_o is hw_int_i delayed SYNC_STAGES cycles, free-running, independent of stall_i.
- Interrupt pending when all of the following hold:
  - ({hw_ip_o, cause_i[9:8]} & status_i[15:8]) != 0
  - status_i[0] = 1
  - status_i[1] = 0
  - block = 0
- Accept condition: inst_valid_i & !stall_i & !flush_o. The cycle after a flush is never accepted.
- Priority among accepted events: interrupt > exc_src_i[0] > ... > exc_src_i[NUM_SRC-1] > eret_i.
- Interrupt commit uses ExcCode 0.
- Exception/interrupt commit, registered, so outputs appear 1 cycle after the accept edge:
  - flush_o = 1, exc_we_o = 1, new_pc_o = EXC_VECTOR.
  - exccode_o = EXC_CODES[idx]; bd_o = in_delay_slot_i.
  - epc_o = in_delay_slot_i ? pc_i - 32'd4 (mod 2^32) : pc_i.
  - badv_we_o = 1 if the winning source is in either mask: pc_i for PC_BADV_MASK, bad_addr_i for DATA_BADV_MASK. Otherwise badv_we_o = 0 and badvaddr_o holds its old value.
- ERET commit (no interrupt, no exception): flush_o = 1, eret_o = 1, new_pc_o = epc_i, exc_we_o = 0.
- All strobes (flush_o, exc_we_o, badv_we_o, eret_o) are exactly one cycle wide. Data outputs hold until the next commit.
- Block flag:
  - Set on an exception/interrupt commit.
  - Cleared when status_i[1] is sampled as 1, or on an ERET commit.
  - Prevents a second interrupt before CP0 EXL lands. Synchronous exceptions are not blocked.
- stall_i = 1 with requests present: nothing commits. Requests are re-evaluated each cycle until the stall drops. No request is latched internally.
- inst_valid_i = 0: no commit, even if an interrupt is pending. The interrupt waits for a valid instruction so EPC is defined.

Decomposition:
- Package exc_pkg holds:
  - ExcCode constants: INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12, TR 13.
  - Default EXC_CODES ordering: ADEL-fetch, RI, OV, SYS, BP, TR, ADEL-data, ADES.
  - EXC_VECTOR.
  - Status/Cause bit-index constants.
- Sub-module: int_sync, a parametrised SYNC_STAGES×HW_INT synchroniser with asynchronous active-low clear.

Test Plan:
- Reset: hold resetn=0 during flush_o=1 → all outputs 0 in the same cycle; after release, the next commit needs a fresh accept.
- exc_src_i=8'b0000_0100 (OV), pc_i=32'h8000_0010, in_delay_slot_i=1 → next cycle:
  - flush_o=1, exc_we_o=1, exccode_o=12, epc_o=32'h8000_000C, bd_o=1, new_pc_o=32'hBFC0_0380, badv_we_o=0.
- Priority: exc_src_i=8'b1000_0001, pc_i=32'hBFC0_0003 → exccode_o=4, badvaddr_o=32'hBFC0_0003, badv_we_o=1.
  - Same request with an interrupt pending → exccode_o=0.
- Interrupt: hw_int_i[0]=1, status_i=32'h0000_0401 → commit exactly SYNC_STAGES+1 cycles later, exccode_o=0.
  - Block holds off a second interrupt while status_i[1]=0.
- Stall: exc_src_i[3]=1 with stall_i=1 for 3 cycles → no strobe; commit 1 cycle after stall_i falls; one-cycle pulses only.
- ERET: eret_i=1, epc_i=32'h8000_1234 → flush_o=1, eret_o=1, new_pc_o=32'h8000_1234, exc_we_o=0, block cleared.
